// File: rtl/disp_pkg.sv
// Shared types and constants for the serial 7-segment / LED display chain controller.
package disp_pkg;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_LO,
        PH_HI,
        PH_LAT
    } phase_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEG,
        ST_LED
    } ctrl_state_t;

    // Active-high gfedcba patterns, entry 0 is the rightmost element.
    localparam logic [15:0][6:0] HEX7_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [7:0] BLANK_BYTE = 8'hFF;

    function automatic logic [7:0] seg_byte(input logic [3:0] nibble, input logic dp,
                                            input logic blank);
        seg_byte = blank ? BLANK_BYTE : ~{dp, HEX7_TABLE[nibble]};
    endfunction

endpackage

// File: rtl/disp_serial_shifter.sv
// Single serial chain engine: shifts WIDTH bits MSB first with LO/HI clock phases,
// then pulses the latch enable. done is high during the final latch cycle.
module disp_serial_shifter
    import disp_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] vec,
    output logic             sclk,
    output logic             sdo,
    output logic             sen,
    output logic             done
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    phase_t           phase;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic             phase_end;

    assign phase_end = (div_cnt == DIV_LAST);
    assign shifted   = shreg << 1;
    assign done      = (phase == PH_LAT) && phase_end;

    // NOTE: non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: shreg stays out of reset; it is always loaded on go before use.
            phase   <= PH_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            sdo     <= 1'b0;
            sen     <= 1'b0;
        end else begin
            case (phase)
                PH_IDLE: begin
                    if (go) begin
                        shreg   <= vec;
                        sdo     <= vec[WIDTH-1];
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        phase   <= PH_LO;
                    end
                end
                PH_LO: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        sclk    <= 1'b1;
                        phase   <= PH_HI;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                PH_HI: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        sclk    <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            sdo   <= 1'b0;
                            sen   <= 1'b1;
                            phase <= PH_LAT;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= shifted;
                            sdo     <= shifted[WIDTH-1];
                            phase   <= PH_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                PH_LAT: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        sen     <= 1'b0;
                        phase   <= PH_IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/disp_chain_ctrl.sv
// Display chain controller: snapshots digits/LEDs and drives the segment chain then the LED chain.
// Optional digit blinking is compiled in with the DISP_BLINK_EN macro.
module disp_chain_ctrl
    import disp_pkg::*;
#(
    parameter int N_DIGITS       = 8,
    parameter int LED_BITS       = 16,
    parameter int CLK_DIV        = 2,
    parameter int AUTO_REFRESH   = 1,
    parameter int REFRESH_CYCLES = 250000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*N_DIGITS-1:0] data,
    input  logic [N_DIGITS-1:0]   en,
    input  logic [N_DIGITS-1:0]   dot,
    input  logic [LED_BITS-1:0]   led,
`ifdef DISP_BLINK_EN
    input  logic [N_DIGITS-1:0]   blink,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  seg_clk,
    output logic                  seg_do,
    output logic                  seg_en,
    output logic                  led_clk,
    output logic                  led_do,
    output logic                  led_en,
    output logic                  seg_clr_n,
    output logic                  led_clr_n
);

    localparam int SEG_BITS = 8 * N_DIGITS;
    localparam int CNT_W    = $clog2(REFRESH_CYCLES + 1);
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);

    ctrl_state_t         state;
    logic [CNT_W-1:0]    refresh_cnt;
    logic [LED_BITS-1:0] led_snap;
    logic [N_DIGITS-1:0] hide;
    logic [SEG_BITS-1:0] seg_vec;
    logic                auto_hit;
    logic                accept;
    logic                led_go;
    logic                seg_done;
    logic                led_done;

    assign auto_hit = (AUTO_REFRESH != 0) && (refresh_cnt == REFRESH_LAST);
    assign accept   = (state == ST_IDLE) && (start || auto_hit);
    assign led_go   = (state == ST_SEG) && seg_done;

`ifdef DISP_BLINK_EN
    logic       blink_on;
    logic [5:0] xfer_cnt;

    assign hide = ~en | (blink & {N_DIGITS{~blink_on}});

    // Phase flips after every 64th completed transfer; the counter wraps on its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_on <= 1'b1;
            xfer_cnt <= '0;
        end else if ((state == ST_LED) && led_done) begin
            xfer_cnt <= xfer_cnt + 1'b1;
            if (xfer_cnt == 6'd63) begin
                blink_on <= ~blink_on;
            end
        end
    end
`else
    assign hide = ~en;
`endif

    // NOTE: default assignment first so the digit loop can never infer a latch.
    always_comb begin
        seg_vec = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            seg_vec[8*i +: 8] = seg_byte(data[4*i +: 4], dot[i], hide[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            refresh_cnt <= '0;
            seg_clr_n   <= 1'b0;
            led_clr_n   <= 1'b0;
        end else begin
            seg_clr_n <= 1'b1;
            led_clr_n <= 1'b1;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        led_snap    <= led;
                        refresh_cnt <= '0;
                        busy        <= 1'b1;
                        state       <= ST_SEG;
                    end else begin
                        refresh_cnt <= refresh_cnt + 1'b1;
                    end
                end
                ST_SEG: begin
                    if (seg_done) begin
                        state <= ST_LED;
                    end
                end
                ST_LED: begin
                    if (led_done) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The segment image is captured straight into the shifter on accept; the LED
    // vector waits in led_snap until the segment chain has latched.
    disp_serial_shifter #(
        .WIDTH   (SEG_BITS),
        .CLK_DIV (CLK_DIV)
    ) u_seg_chain (
        .clk  (clk),
        .rst  (rst),
        .go   (accept),
        .vec  (seg_vec),
        .sclk (seg_clk),
        .sdo  (seg_do),
        .sen  (seg_en),
        .done (seg_done)
    );

    disp_serial_shifter #(
        .WIDTH   (LED_BITS),
        .CLK_DIV (CLK_DIV)
    ) u_led_chain (
        .clk  (clk),
        .rst  (rst),
        .go   (led_go),
        .vec  (led_snap),
        .sclk (led_clk),
        .sdo  (led_do),
        .sen  (led_en),
        .done (led_done)
    );

endmodule

// File: tb/tb_disp_chain_ctrl.sv
// Directed bench for disp_chain_ctrl: a start-driven instance and a self-refreshing instance.
module tb_disp_chain_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] data = '0;
    logic [7:0]  en = '0;
    logic [7:0]  dot = '0;
    logic [15:0] led = '0;
`ifdef DISP_BLINK_EN
    logic [7:0]  blink = '0;
`endif

    logic busy, done, seg_clk, seg_do, seg_en, led_clk, led_do, led_en, seg_clr_n, led_clr_n;
    logic busy_a, done_a, seg_clk_a, seg_do_a, seg_en_a, led_clk_a, led_do_a, led_en_a;
    logic seg_clr_n_a, led_clr_n_a;

    int errors = 0;
    int checks = 0;

    int          busy_cycles, done_count, seg_nbits, led_nbits;
    int          seg_en_cycles, seg_en_pulses, led_en_cycles, led_en_pulses;
    logic [63:0] seg_bits;
    logic [15:0] led_bits;
    logic        done_ok, timed_out;

    always #20 clk = ~clk;

    disp_chain_ctrl #(
        .N_DIGITS(8), .LED_BITS(16), .CLK_DIV(2), .AUTO_REFRESH(0), .REFRESH_CYCLES(250000)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .en(en), .dot(dot), .led(led),
`ifdef DISP_BLINK_EN
        .blink(blink),
`endif
        .busy(busy), .done(done), .seg_clk(seg_clk), .seg_do(seg_do), .seg_en(seg_en),
        .led_clk(led_clk), .led_do(led_do), .led_en(led_en),
        .seg_clr_n(seg_clr_n), .led_clr_n(led_clr_n)
    );

    disp_chain_ctrl #(
        .N_DIGITS(8), .LED_BITS(16), .CLK_DIV(2), .AUTO_REFRESH(1), .REFRESH_CYCLES(1000)
    ) dut_auto (
        .clk(clk), .rst(rst), .start(1'b0), .data(32'h0123_4567), .en(8'hFF), .dot(8'h00),
        .led(16'h5A5A),
`ifdef DISP_BLINK_EN
        .blink(8'h00),
`endif
        .busy(busy_a), .done(done_a), .seg_clk(seg_clk_a), .seg_do(seg_do_a), .seg_en(seg_en_a),
        .led_clk(led_clk_a), .led_do(led_do_a), .led_en(led_en_a),
        .seg_clr_n(seg_clr_n_a), .led_clr_n(led_clr_n_a)
    );

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Samples one transfer at negedges, starting on the first busy cycle.
    // inject_at > 0 raises start with altered inputs on that busy cycle.
    task automatic capture(input int inject_at);
        logic p_sclk, p_lclk, p_sen, p_len, injected;
        int   idle_after;
        busy_cycles = 0; done_count = 0; seg_nbits = 0; led_nbits = 0;
        seg_en_cycles = 0; seg_en_pulses = 0; led_en_cycles = 0; led_en_pulses = 0;
        seg_bits = '0; led_bits = '0; done_ok = 1'b0; timed_out = 1'b1;
        p_sclk = 1'b0; p_lclk = 1'b0; p_sen = 1'b0; p_len = 1'b0; injected = 1'b0;
        idle_after = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (injected) start = 1'b0;
            if (busy) busy_cycles++;
            if (done) begin
                done_count++;
                if (!busy && busy_cycles > 0 && idle_after == 0) done_ok = 1'b1;
            end
            if (seg_clk && !p_sclk) begin seg_bits = {seg_bits[62:0], seg_do}; seg_nbits++; end
            if (led_clk && !p_lclk) begin led_bits = {led_bits[14:0], led_do}; led_nbits++; end
            if (seg_en) seg_en_cycles++;
            if (seg_en && !p_sen) seg_en_pulses++;
            if (led_en) led_en_cycles++;
            if (led_en && !p_len) led_en_pulses++;
            p_sclk = seg_clk; p_lclk = led_clk; p_sen = seg_en; p_len = led_en;
            if (!busy && busy_cycles > 0) idle_after++;
            if (inject_at > 0 && busy && busy_cycles == inject_at && !injected) begin
                data = 32'hFFFF_FFFF; en = '0; dot = '1; led = ~led;
                start = 1'b1; injected = 1'b1;
            end
            if (idle_after == 4) begin timed_out = 1'b0; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, seg_clk, seg_do, seg_en, led_clk, led_do, led_en, seg_clr_n, led_clr_n} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000000",
                     {busy, done, seg_clk, seg_do, seg_en, led_clk, led_do, led_en, seg_clr_n, led_clr_n});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({seg_clr_n, led_clr_n, busy} !== 3'b110) begin
            errors++;
            $display("FAIL reset_release: clr_n/busy got %b expected 110", {seg_clr_n, led_clr_n, busy});
        end
    endtask

    task automatic test_basic;
        data = 32'h0123_4567; en = 8'hFF; dot = 8'h00; led = 16'hA5C3;
        pulse_start();
        capture(0);
        checks++;
        if (timed_out !== 1'b0) begin errors++; $display("FAIL basic_timeout: transfer did not finish"); end
        checks++;
        if (busy_cycles !== 324) begin errors++; $display("FAIL basic_busy_len: got %0d expected 324", busy_cycles); end
        checks++;
        if (seg_nbits !== 64 || seg_bits !== 64'hC0F9_A4B0_9992_82F8) begin
            errors++; $display("FAIL basic_seg_stream: got %0d bits %h expected 64 bits c0f9a4b0999282f8", seg_nbits, seg_bits);
        end
        checks++;
        if (led_nbits !== 16 || led_bits !== 16'hA5C3) begin
            errors++; $display("FAIL basic_led_stream: got %0d bits %h expected 16 bits a5c3", led_nbits, led_bits);
        end
        checks++;
        if (seg_en_pulses !== 1 || seg_en_cycles !== 2) begin
            errors++; $display("FAIL basic_seg_latch: got %0d pulses %0d cycles expected 1 and 2", seg_en_pulses, seg_en_cycles);
        end
        checks++;
        if (led_en_pulses !== 1 || led_en_cycles !== 2) begin
            errors++; $display("FAIL basic_led_latch: got %0d pulses %0d cycles expected 1 and 2", led_en_pulses, led_en_cycles);
        end
        checks++;
        if (done_count !== 1 || done_ok !== 1'b1) begin
            errors++; $display("FAIL basic_done: got count %0d on_first_idle %b expected 1 and 1", done_count, done_ok);
        end
        checks++;
        if ({seg_clk, seg_do, seg_en, led_clk, led_do, led_en} !== 6'b0) begin
            errors++; $display("FAIL basic_idle_levels: got %b expected 000000",
                               {seg_clk, seg_do, seg_en, led_clk, led_do, led_en});
        end
    endtask

    task automatic test_blank_dot;
        data = 32'h89AB_CDEF; en = 8'h01; dot = 8'h01; led = 16'h8001;
        pulse_start();
        capture(0);
        checks++;
        if (timed_out !== 1'b0 || seg_bits !== 64'hFFFF_FFFF_FFFF_FF0E) begin
            errors++; $display("FAIL blank_seg_stream: got %h timeout %b expected ffffffffffffff0e", seg_bits, timed_out);
        end
        checks++;
        if (led_bits !== 16'h8001) begin errors++; $display("FAIL blank_led_stream: got %h expected 8001", led_bits); end
    endtask

    task automatic test_back_to_back_start;
        data = 32'h0123_4567; en = 8'hFF; dot = 8'h00; led = 16'h1234;
        pulse_start();
        capture(10);
        checks++;
        if (timed_out !== 1'b0 || seg_bits !== 64'hC0F9_A4B0_9992_82F8) begin
            errors++; $display("FAIL ignore_seg_stream: got %h timeout %b expected c0f9a4b0999282f8", seg_bits, timed_out);
        end
        checks++;
        if (led_bits !== 16'h1234) begin errors++; $display("FAIL ignore_led_stream: got %h expected 1234", led_bits); end
        checks++;
        if (done_count !== 1 || busy_cycles !== 324) begin
            errors++; $display("FAIL ignore_single_xfer: got done %0d busy %0d expected 1 and 324", done_count, busy_cycles);
        end
    endtask

    task automatic test_reset_mid;
        logic found, bad;
        data = 32'h89AB_CDEF; en = 8'hFF; dot = 8'h00; led = 16'hFFFF;
        pulse_start();
        found = 1'b0; bad = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (led_en || done) bad = 1'b1;
            if (led_clk) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (found !== 1'b1) begin errors++; $display("FAIL rstmid_reach_led_hi: got %b expected 1", found); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, seg_clk, seg_do, seg_en, led_clk, led_do, led_en, seg_clr_n, led_clr_n} !== 10'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %b expected 0000000000",
                     {busy, done, seg_clk, seg_do, seg_en, led_clk, led_do, led_en, seg_clr_n, led_clr_n});
        end
        repeat (3) begin
            @(negedge clk);
            if (led_en || done) bad = 1'b1;
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (busy || done || led_en || seg_en) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin errors++; $display("FAIL rstmid_no_latch_done: got %b expected 0", bad); end
        checks++;
        if ({seg_clr_n, led_clr_n} !== 2'b11) begin
            errors++; $display("FAIL rstmid_clr_n: got %b expected 11", {seg_clr_n, led_clr_n});
        end
        data = 32'h0123_4567; led = 16'h0F0F;
        pulse_start();
        capture(0);
        checks++;
        if (timed_out !== 1'b0 || seg_bits !== 64'hC0F9_A4B0_9992_82F8 || led_bits !== 16'h0F0F || done_count !== 1) begin
            errors++; $display("FAIL rstmid_after_release: got seg %h led %h done %0d expected c0f9a4b0999282f8 0f0f 1",
                               seg_bits, led_bits, done_count);
        end
    endtask

    task automatic test_auto_refresh;
        int first, len, idle;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        first = -1;
        for (int k = 1; k <= 1100; k++) begin
            @(negedge clk);
            if (busy_a) begin first = k; break; end
        end
        checks++;
        if (first !== 1000) begin errors++; $display("FAIL auto_first_start: got cycle %0d expected 1000", first); end
        len = 0;
        for (int k = 0; k < 400 && busy_a; k++) begin
            len++;
            @(negedge clk);
        end
        checks++;
        if (len !== 324) begin errors++; $display("FAIL auto_busy_len: got %0d expected 324", len); end
        checks++;
        if (done_a !== 1'b1) begin errors++; $display("FAIL auto_done: got %b expected 1", done_a); end
        idle = 0;
        for (int k = 0; k < 1100 && !busy_a; k++) begin
            if ({seg_clk_a, seg_do_a, seg_en_a, led_clk_a, led_do_a, led_en_a} !== 6'b0 ||
                {seg_clr_n_a, led_clr_n_a} !== 2'b11) idle = -5000;
            idle++;
            @(negedge clk);
        end
        checks++;
        if (idle !== 1000) begin errors++; $display("FAIL auto_idle_gap: got %0d expected 1000", idle); end
    endtask

`ifdef DISP_BLINK_EN
    task automatic test_blink;
        logic [63:0] expected;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        data = 32'h0123_4567; en = 8'hFF; dot = 8'h00; led = 16'h00FF; blink = 8'h80;
        for (int t = 1; t <= 128; t++) begin
            pulse_start();
            capture(0);
            expected = (t <= 64) ? 64'hC0F9_A4B0_9992_82F8 : 64'hFFF9_A4B0_9992_82F8;
            checks++;
            if (timed_out !== 1'b0 || seg_bits !== expected) begin
                errors++; $display("FAIL blink_xfer_%0d: got %h expected %h", t, seg_bits, expected);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_blank_dot();
        test_back_to_back_start();
        test_reset_mid();
        test_auto_refresh();
`ifdef DISP_BLINK_EN
        test_blink();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/disp_chain_ctrl.md
Name: disp_chain_ctrl

Overview:
- Parametrised successor to the board's serial 7-segment/LED display driver.
- Snapshots hex digits, digit enables, dots and a LED vector, then shifts them out over two independent serial chains: segment chain first, LED chain second. Each chain has its own clk/do/latch-enable.
- Supports explicit start/busy/done handshake plus optional self-timed refresh.
- Sits beside btn_scan in the board top, clocked by the 25 MHz display clock.

Parameters:
- N_DIGITS, 8, number of 7-seg digits (1..16); segment chain length = 8*N_DIGITS bits
- LED_BITS, 16, LED chain length (1..32)
- CLK_DIV, 2, clk cycles per serial-clock half period (>=1)
- AUTO_REFRESH, 1, 1 = self-start every REFRESH_CYCLES; 0 = start input only
- REFRESH_CYCLES, 250000, idle-to-auto-start interval in clk cycles (> transfer length)

Ports:
- clk  in  1  display clock
- rst  in  1  synchronous active-high reset
- start  in  1  request transfer; sampled only in IDLE
- data  in  4*N_DIGITS  hex nibbles; digit i = data[4i+3:4i]
- en  in  N_DIGITS  digit enable; 0 blanks digit
- dot  in  N_DIGITS  decimal point per digit, 1 = lit
- led  in  LED_BITS  LED pattern, shifted unmodified
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- seg_clk, seg_do, seg_en  out  1 each  segment chain clock / data / latch
- led_clk, led_do, led_en  out  1 each  LED chain clock / data / latch
- seg_clr_n, led_clr_n  out  1 each  chain clear, active-low

Behaviour:
- Reset:
  - busy=0, done=0, all *_clk/*_do/*_en=0, *_clr_n=0 while rst is high.
  - *_clr_n=1 from the first cycle after rst drops.
  - Refresh counter=0, FSM=IDLE.
- Reset mid-transfer: all outputs return to reset values on the next edge. No latch pulse; done not asserted; snapshot discarded.
- FSM states: IDLE -> SEG_LO -> SEG_HI -> (repeat per bit) -> SEG_LAT -> LED_LO -> LED_HI -> (repeat) -> LED_LAT -> IDLE.
- Accept: in IDLE, a cycle with start=1 (or auto trigger) snapshots data/en/dot/led and moves to SEG_LO; busy=1 from the next cycle.
  - start while busy is ignored (not queued).
  - start and auto trigger in the same cycle produce one transfer.
- Per bit:
  - LO phase: *_do driven, *_clk=0 for CLK_DIV cycles.
  - HI phase: *_clk=1 for CLK_DIV cycles; *_do held stable.
  - Receiver samples on the rising edge.
- LAT: *_clk=0 and *_en=1 for CLK_DIV cycles, then *_en=0.
- Segment byte for digit i, MSB first: active-low {dp,g,f,e,d,c,b,a} = ~{dot[i], hex7(data nibble)}.
  - en[i]=0 -> 8'hFF.
  - Digit N_DIGITS-1 is shifted first.
- LED chain: led[LED_BITS-1] first, bits passed as-is.
- Idle levels: *_do=0, *_clk=0, *_en=0.
- Timing:
  - busy high for exactly (8*N_DIGITS+LED_BITS)*2*CLK_DIV + 2*CLK_DIV cycles.
  - done=1 for exactly one cycle, the first cycle with busy=0 after a completed transfer.
- Auto refresh (AUTO_REFRESH=1):
  - Counter increments only in IDLE and clears on any accept.
  - Reaching REFRESH_CYCLES-1 triggers an accept.
- Inputs may change freely during busy without affecting the current transfer.

Optional Feature:
- Macro: DISP_BLINK_EN.
- When defined:
  - Extra input blink [N_DIGITS].
  - Internal blink phase toggles every 64 completed transfers; reset phase = on.
  - While phase = off, digits with blink[i]=1 shift 8'hFF.
- When undefined: no blink port, no phase register; behaviour identical to blink=0.

Decomposition:
- Package disp_pkg: FSM state enum, 16-entry hex7 segment constant table (0->7'h3F … F->7'h71, gfedcba active-high), blank byte 8'hFF.
- One natural sub-module, disp_serial_shifter: generic single-chain LO/HI/LAT engine with parameters WIDTH and CLK_DIV, and go/load-vector/done handshake. Instantiated twice and sequenced by the top FSM.

Test Plan:
- N_DIGITS=8, LED_BITS=16, CLK_DIV=2, AUTO_REFRESH=0; data=32'h0123_4567, en=8'hFF, dot=0, pulse start -> busy high 324 cycles; captured seg stream bytes (first..last) C0,F9,A4,B0,99,92,82,F8; led stream matches led; one seg_en and one led_en pulse of 2 cycles; done pulses once.
- en=8'h01, dot=8'h01, data nibble0=4'hF -> first 7 bytes FF, last byte 0E.
- Assert start on the 10th busy cycle with different data -> ignored; stream unchanged; exactly one done.
- Assert rst during LED_HI -> next cycle all chain outputs 0, clr_n 0, busy 0; no latch pulse or done; after release, start works normally.
- AUTO_REFRESH=1, REFRESH_CYCLES=1000, start tied 0 -> first busy rise at cycle 1000 after reset; subsequent transfer starts exactly 1000 idle cycles after each done.
- DISP_BLINK_EN defined, blink=8'h80 -> transfers 1–64 show digit 7 normally; transfers 65–128 shift FF for digit 7 only.
